tmds_chan_align_dec: RTL and testbench

- Parametrised per-channel TMDS word aligner and decoder, one instance per TMDS lane, after the 1:10 deserializer.
- Searches for DVI control tokens and issues bitslip pulses until word alignment is found. Declares lock after a run of consecutive tokens.
- While locked, outputs decoded 8-bit pixel data, a data-enable and 2-bit control, all pipeline-aligned.
- Adds over the previous generation: programmable thresholds, a settle gap after each slip, polarity inversion, a lock flag, a slip counter and a sticky alignment-failure flag.

---
 rtl/tmds_chan_align_dec.sv | 223 ++++++++++++++++++++++
 tb/tb_tmds_chan_align_dec.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_chan_align_dec.sv
// Per-lane TMDS word aligner and decoder: hunts for DVI control tokens with bitslip,
// locks after a run of tokens, then decodes pixel bytes with a fixed 2-cycle latency.
module tmds_chan_align_dec #(
    parameter int         SEARCH_MAX   = 2047,
    parameter int         HIT_RUN      = 9,
    parameter int         SYNC_TIMEOUT = 4095,
    parameter int         SLIP_SETTLE  = 3,
    parameter int         CNT_W        = 12,
    parameter logic [1:0] CTRL_IDLE    = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       invert,
    input  logic [9:0] data_in,
    output logic       bitslip,
    output logic [7:0] data_out,
    output logic       de,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] slip_cnt,
    output logic       align_err
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SEARCH = 3'd1;
    localparam logic [2:0] ST_HIT    = 3'd2;
    localparam logic [2:0] ST_LOCK   = 3'd3;
    localparam logic [2:0] ST_SLIP   = 3'd4;
    localparam logic [2:0] ST_SETTLE = 3'd5;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] SEARCH_LIM = CNT_W'(SEARCH_MAX);
    localparam logic [CNT_W-1:0] HIT_LIM    = CNT_W'(HIT_RUN - 32'sd1);
    localparam logic [CNT_W-1:0] SYNC_LIM   = CNT_W'(SYNC_TIMEOUT);
    localparam logic [CNT_W-1:0] SETTLE_LIM = CNT_W'(SLIP_SETTLE - 32'sd1);
    localparam logic             HIT_ONE    = (HIT_RUN == 32'sd1);

    // {match, c1c0} for the four DVI control tokens
    function automatic logic [2:0] tok_decode(input logic [9:0] w);
        logic [2:0] r;
        case (w)
            10'b1101010100: r = 3'b1_00;
            10'b0010101011: r = 3'b1_01;
            10'b0101010100: r = 3'b1_10;
            10'b1010101011: r = 3'b1_11;
            default:        r = 3'b0_00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] d);
        logic [7:0] q;
        logic [7:0] r;
        q    = d[9] ? ~d[7:0] : d[7:0];
        r    = 8'h00;
        r[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            r[i] = d[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return r;
    endfunction

    logic [9:0]       w_s;
    logic [2:0]       tok_dec_s;
    logic [9:0]       d_r;
    logic             tok_r;
    logic [1:0]       tok_ctrl_r;
    logic [2:0]       state_r, state_nx_s;
    logic [CNT_W-1:0] search_cnt_r, search_nx_s;
    logic [CNT_W-1:0] hit_cnt_r, hit_nx_s;
    logic [CNT_W-1:0] sync_cnt_r, sync_nx_s;
    logic [CNT_W-1:0] settle_cnt_r, settle_nx_s;

    assign w_s = data_in ^ {10{invert}};

    // token classification of the polarity-corrected input word
    always_comb begin
        tok_dec_s = tok_decode(w_s);
    end

    // stage 1: register the corrected word and its token match
    always_ff @(posedge clk) begin
        if (rst) begin
            d_r        <= 10'h000;
            tok_r      <= 1'b0;
            tok_ctrl_r <= 2'b00;
        end else begin
            d_r        <= w_s;
            tok_r      <= tok_dec_s[2];
            tok_ctrl_r <= tok_dec_s[1:0];
        end
    end

    // alignment FSM next state and counter updates
    always_comb begin
        state_nx_s  = state_r;
        search_nx_s = search_cnt_r;
        hit_nx_s    = hit_cnt_r;
        sync_nx_s   = sync_cnt_r;
        settle_nx_s = settle_cnt_r;
        case (state_r)
            ST_IDLE: begin
                state_nx_s  = ST_SEARCH;
                search_nx_s = CNT_ZERO;
            end
            ST_SEARCH: begin
                if (tok_r) begin
                    if (HIT_ONE) begin
                        state_nx_s = ST_LOCK;
                        sync_nx_s  = CNT_ZERO;
                    end else begin
                        state_nx_s = ST_HIT;
                        hit_nx_s   = CNT_ONE;
                    end
                end else if (search_cnt_r == SEARCH_LIM) begin
                    state_nx_s = ST_SLIP;
                end else begin
                    search_nx_s = search_cnt_r + CNT_ONE;
                end
            end
            ST_SLIP: begin
                state_nx_s  = ST_SETTLE;
                settle_nx_s = CNT_ZERO;
            end
            ST_SETTLE: begin
                if (settle_cnt_r == SETTLE_LIM) begin
                    state_nx_s  = ST_SEARCH;
                    search_nx_s = CNT_ZERO;
                end else begin
                    settle_nx_s = settle_cnt_r + CNT_ONE;
                end
            end
            ST_HIT: begin
                if (!tok_r) begin
                    state_nx_s  = ST_SEARCH;
                    search_nx_s = CNT_ZERO;
                end else if (hit_cnt_r == HIT_LIM) begin
                    state_nx_s = ST_LOCK;
                    sync_nx_s  = CNT_ZERO;
                end else begin
                    hit_nx_s = hit_cnt_r + CNT_ONE;
                end
            end
            ST_LOCK: begin
                if (tok_r) begin
                    sync_nx_s = CNT_ZERO;
                end else if (sync_cnt_r == SYNC_LIM) begin
                    state_nx_s  = ST_SEARCH;
                    search_nx_s = CNT_ZERO;
                end else begin
                    sync_nx_s = sync_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            search_cnt_r <= CNT_ZERO;
            hit_cnt_r    <= CNT_ZERO;
            sync_cnt_r   <= CNT_ZERO;
            settle_cnt_r <= CNT_ZERO;
        end else begin
            state_r      <= state_nx_s;
            search_cnt_r <= search_nx_s;
            hit_cnt_r    <= hit_nx_s;
            sync_cnt_r   <= sync_nx_s;
            settle_cnt_r <= settle_nx_s;
        end
    end

    // status: slip pulse, lock flag, slip counter and sticky rotation failure
    always_ff @(posedge clk) begin
        if (rst) begin
            bitslip   <= 1'b0;
            locked    <= 1'b0;
            slip_cnt  <= 4'd0;
            align_err <= 1'b0;
        end else begin
            bitslip <= (state_r == ST_SLIP);
            locked  <= (state_r == ST_LOCK);
            if ((state_nx_s == ST_LOCK) && (state_r != ST_LOCK)) begin
                slip_cnt  <= 4'd0;
                align_err <= 1'b0;
            end else if (state_r == ST_SLIP) begin
                if (slip_cnt == 4'd9) begin
                    slip_cnt  <= 4'd0;
                    align_err <= 1'b1;
                end else begin
                    slip_cnt <= slip_cnt + 4'd1;
                end
            end
        end
    end

    // output stage: decoded data while locked, idle values otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= 8'h00;
            de       <= 1'b0;
            ctrl     <= CTRL_IDLE;
        end else if ((state_r == ST_LOCK) && tok_r) begin
            data_out <= 8'h00;
            de       <= 1'b0;
            ctrl     <= tok_ctrl_r;
        end else if (state_r == ST_LOCK) begin
            data_out <= tmds_decode(d_r);
            de       <= 1'b1;
            ctrl     <= CTRL_IDLE;
        end else begin
            data_out <= 8'h00;
            de       <= 1'b0;
            ctrl     <= CTRL_IDLE;
        end
    end

endmodule

// File: tb/tb_tmds_chan_align_dec.sv
// Scoreboard bench for tmds_chan_align_dec: a behavioural link/receiver model predicts
// every output cycle; a separate monitor compares the DUT against the queued predictions.
module tb_tmds_chan_align_dec;

    localparam int SEARCH_MAX   = 2047;
    localparam int HIT_RUN      = 9;
    localparam int SYNC_TIMEOUT = 4095;
    localparam int SLIP_SETTLE  = 3;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst;
    logic       invert;
    logic [9:0] data_in;
    logic       bitslip;
    logic [7:0] data_out;
    logic       de;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] slip_cnt;
    logic       align_err;

    tmds_chan_align_dec #(
        .SEARCH_MAX(SEARCH_MAX), .HIT_RUN(HIT_RUN), .SYNC_TIMEOUT(SYNC_TIMEOUT),
        .SLIP_SETTLE(SLIP_SETTLE), .CNT_W(12), .CTRL_IDLE(2'b11)
    ) dut (
        .clk(clk), .rst(rst), .invert(invert), .data_in(data_in), .bitslip(bitslip),
        .data_out(data_out), .de(de), .ctrl(ctrl), .locked(locked),
        .slip_cnt(slip_cnt), .align_err(align_err)
    );

    initial forever #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] due;
        logic        de;
        logic [7:0]  dout;
        logic [1:0]  ctrl;
        logic        lck;
        logic        slp;
        logic [3:0]  sc;
        logic        err;
    } rec_t;

    rec_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   slip_total = 0;
    int   off0 = 0;
    int   mark = 0;
    bit   prev_rst = 1'b1;

    // receiver model: lock flag, token run, quiet-cycle count, blind window after a slip
    bit m_lock, m_err;
    int m_quiet, m_run, m_blind, m_slip;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // deserializer side: every observed slip pulse advances the link rotation
    initial forever begin
        @(negedge clk);
        if (bitslip === 1'b1) slip_total++;
    end

    function automatic int tok_idx(input logic [9:0] w);
        logic [9:0] tk [4];
        tk = '{T0, T1, T2, T3};
        for (int i = 0; i < 4; i++) if (w == tk[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] d);
        logic [7:0] q;
        logic [7:0] r;
        logic       x;
        q = d[7:0];
        if (d[9]) q = ~q;
        r = 8'h00;
        r[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            x = q[i] ^ q[i-1];
            r[i] = d[8] ? x : ~x;
        end
        return r;
    endfunction

    function automatic logic [9:0] rot(input logic [9:0] w, input int o);
        logic [19:0] ww;
        ww = {w, w} >> o;
        return ww[9:0];
    endfunction

    function automatic logic [9:0] nontok_rand();
        logic [9:0] w;
        w = 10'($urandom);
        if (tok_idx(w) >= 0) w = 10'h1AB;
        return w;
    endfunction

    task automatic model_reset();
        m_lock = 1'b0; m_err = 1'b0; m_quiet = 0; m_run = 0; m_blind = 0; m_slip = 0;
    endtask

    task automatic model_step(input logic [9:0] w, output rec_t r);
        int k;
        k = tok_idx(w);
        r = '0;
        r.ctrl = 2'b11;
        r.lck  = m_lock;
        r.slp  = (m_blind == SLIP_SETTLE + 1);
        if (m_lock) begin
            if (k >= 0) r.ctrl = 2'(k);
            else begin
                r.de   = 1'b1;
                r.dout = ref_decode(w);
            end
        end
        if (m_blind > 0) begin
            if (m_blind == SLIP_SETTLE + 1) begin
                m_slip = (m_slip + 1) % 10;
                if (m_slip == 0) m_err = 1'b1;
            end
            m_blind--;
            m_quiet = 0;
        end else if (m_lock) begin
            if (k >= 0) m_quiet = 0;
            else if (m_quiet == SYNC_TIMEOUT) begin
                m_lock = 1'b0; m_quiet = 0; m_run = 0;
            end else m_quiet++;
        end else if (k >= 0) begin
            m_run++;
            m_quiet = 0;
            if (m_run == HIT_RUN) begin
                m_lock = 1'b1; m_run = 0; m_slip = 0; m_err = 1'b0;
            end
        end else if (m_run > 0) begin
            m_run = 0; m_quiet = 0;
        end else if (m_quiet == SEARCH_MAX) begin
            m_blind = SLIP_SETTLE + 1; m_quiet = 0;
        end else m_quiet++;
        r.sc  = 4'(m_slip);
        r.err = m_err;
    endtask

    task automatic push_reset_rec(input int due);
        rec_t r;
        r = '0;
        r.due  = 32'(due);
        r.ctrl = 2'b11;
        sb.push_back(r);
    endtask

    task automatic drive(input logic r, input logic [9:0] tx);
        rec_t e;
        @(posedge clk);
        #1;
        rst = r;
        data_in = tx;
        if (r) begin
            while (sb.size() > 0 && int'(sb[sb.size()-1].due) > cyc) void'(sb.pop_back());
            push_reset_rec(cyc + 1);
            model_reset();
        end else begin
            if (prev_rst) push_reset_rec(cyc + 1);
            model_step(tx ^ {10{invert}}, e);
            e.due = 32'(cyc + 2);
            sb.push_back(e);
        end
        prev_rst = r;
    endtask

    task automatic drive_link(input logic [9:0] w);
        drive(1'b0, rot(w, (off0 + slip_total - mark) % 10));
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: compare each cycle's outputs against the prediction due in that cycle
    initial forever begin
        rec_t e;
        @(negedge clk);
        while (sb.size() > 0 && int'(sb[0].due) < cyc) begin
            e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL sb_stale: entry due %0d never compared (cycle %0d)", e.due, cyc);
        end
        if (sb.size() > 0 && int'(sb[0].due) == cyc) begin
            e = sb.pop_front();
            n_checks++;
            if ({de, data_out, ctrl, locked, bitslip, slip_cnt, align_err} !==
                {e.de, e.dout, e.ctrl, e.lck, e.slp, e.sc, e.err}) begin
                n_fail++;
                $display("FAIL sb cyc=%0d: got de=%b dout=%h ctrl=%b locked=%b bitslip=%b slip_cnt=%0d align_err=%b expected de=%b dout=%h ctrl=%b locked=%b bitslip=%b slip_cnt=%0d align_err=%b",
                         cyc, de, data_out, ctrl, locked, bitslip, slip_cnt, align_err,
                         e.de, e.dout, e.ctrl, e.lck, e.slp, e.sc, e.err);
            end
        end
    end

    initial begin
        logic [9:0] tk [4];
        bit ok;
        int mark2;
        tk = '{T0, T1, T2, T3};
        rst = 1'b1; invert = 1'b0; data_in = 10'h000;
        model_reset();

        repeat (4) drive(1'b1, 10'h000);
        check("rst_bitslip", 32'(bitslip), 32'd0);
        check("rst_de", 32'(de), 32'd0);
        check("rst_ctrl", 32'(ctrl), 32'd3);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_slip_cnt", 32'(slip_cnt), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);

        // aligned token stream
        off0 = 0; mark = slip_total;
        repeat (40) drive_link(T0);
        check("a_locked", 32'(locked), 32'd1);
        check("a_no_slip", 32'(slip_total - mark), 32'd0);

        // locked traffic: random data interleaved with random tokens
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) drive_link(tk[$urandom_range(0, 3)]);
            else drive_link(10'($urandom));
        end
        drive_link(10'h1AB);
        drive_link(T0);
        drive_link(T0);
        @(negedge clk);
        check("b_dout_1ab", 32'(data_out), 32'hFD);
        check("b_de_1ab", 32'(de), 32'd1);
        check("b_ctrl_1ab", 32'(ctrl), 32'd3);

        // stream misrotated by 3 bits
        repeat (3) drive(1'b1, 10'h000);
        off0 = 3; mark = slip_total; ok = 1'b0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            drive_link(T0);
            ok = locked;
        end
        check("c_lock_reached", 32'(ok), 32'd1);
        check("c_slips", 32'(slip_total - mark), 32'd7);
        repeat (10) drive_link(T0);
        check("c_slip_cnt", 32'(slip_cnt), 32'd0);
        check("c_align_err", 32'(align_err), 32'd0);

        // no tokens for a full rotation
        repeat (3) drive(1'b1, 10'h000);
        off0 = 0; mark = slip_total;
        for (int i = 0; i < 25000 && (slip_total - mark) < 10; i++) drive_link(10'h000);
        check("d_ten_slips", 32'(slip_total - mark), 32'd10);
        repeat (2) drive_link(10'h000);
        check("d_align_err", 32'(align_err), 32'd1);
        check("d_slip_cnt", 32'(slip_cnt), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            drive_link(T0);
            ok = locked;
        end
        check("d_relock", 32'(ok), 32'd1);
        repeat (3) drive_link(T0);
        check("d_err_cleared", 32'(align_err), 32'd0);

        // sync timeout, then token exactly in the timeout cycle
        repeat (SYNC_TIMEOUT + 1) drive_link(nontok_rand());
        repeat (3) drive_link(nontok_rand());
        check("e_unlocked", 32'(locked), 32'd0);
        check("e_de_low", 32'(de), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            drive_link(T0);
            ok = locked;
        end
        check("e_relock", 32'(ok), 32'd1);
        repeat (SYNC_TIMEOUT) drive_link(nontok_rand());
        drive_link(T1);
        repeat (10) drive_link(nontok_rand());
        check("e_lock_kept", 32'(locked), 32'd1);

        // swapped pair, then reset in the middle of the post-slip settle window
        repeat (3) drive(1'b1, 10'h000);
        invert = 1'b1; off0 = 0; mark = slip_total;
        repeat (30) drive_link(~T0);
        check("f_inv_locked", 32'(locked), 32'd1);
        check("f_inv_ctrl", 32'(ctrl), 32'd0);
        check("f_inv_no_slip", 32'(slip_total - mark), 32'd0);
        repeat (3) drive(1'b1, 10'h000);
        mark = slip_total;
        for (int i = 0; i < 3000 && slip_total == mark; i++) drive_link(10'h3FF);
        check("f_slip_seen", 32'(slip_total - mark), 32'd1);
        drive(1'b1, 10'h000);
        drive(1'b1, 10'h000);
        check("f_rst_bitslip", 32'(bitslip), 32'd0);
        check("f_rst_slip_cnt", 32'(slip_cnt), 32'd0);
        check("f_rst_ctrl", 32'(ctrl), 32'd3);
        mark2 = slip_total;
        drive(1'b1, 10'h000);
        repeat (200) drive_link(10'h3FF);
        check("f_no_slip_after_rst", 32'(slip_total - mark2), 32'd0);

        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
